// File: rtl/fa4bit_adder_if.sv
// Operand/result bundle for the registered 4-bit adder.
// The master drives the operands, and the slave returns the registered result and flags.
interface fa4bit_adder_if;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic       V;
  logic       Z;
  logic       out_valid;

  modport master (
    output in_valid, A, B, Cin,
    input  S, Cout, V, Z, out_valid
  );

  modport slave (
    input  in_valid, A, B, Cin,
    output S, Cout, V, Z, out_valid
  );
endinterface

// File: rtl/fa4bit_adder.sv
// Registered 4-bit ripple-carry adder built from four full-adder cells.
// Results and flags are presented one cycle after an accepted operand.
module fa4bit_adder (
  input  logic          clk,
  input  logic          rst,
  fa4bit_adder_if.slave bus
);

  logic [4:0] w_c;
  logic [3:0] w_s;
  logic       w_v;
  logic       w_z;

  logic [3:0] r_s;
  logic       r_cout;
  logic       r_v;
  logic       r_z;
  logic       r_out_valid;

  assign w_c[0] = bus.Cin;

  for (genvar i = 0; i < 4; i++) begin : g_cell
    fa4bit_fa_cell u_cell (
      .i_a (bus.A[i]),
      .i_b (bus.B[i]),
      .i_c (w_c[i]),
      .o_s (w_s[i]),
      .o_c (w_c[i+1])
    );
  end

  // V compares the carry into the sign bit with the carry out of it.
  assign w_v = w_c[3] ^ w_c[4];
  assign w_z = (w_s == 4'b0000);

  // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s         <= 4'b0000;
      r_cout      <= 1'b0;
      r_v         <= 1'b0;
      r_z         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s    <= w_s;
        r_cout <= w_c[4];
        r_v    <= w_v;
        r_z    <= w_z;
      end
    end
  end

  assign bus.S         = r_s;
  assign bus.Cout      = r_cout;
  assign bus.V         = r_v;
  assign bus.Z         = r_z;
  assign bus.out_valid = r_out_valid;

endmodule

// One-bit full-adder cell used as a link of the ripple chain.
module fa4bit_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: tb/tb_fa4bit_adder.sv
// Self-checking bench for fa4bit_adder. Expected results are queued when each operand is driven.
// They are popped and compared one cycle later against the registered outputs.
module tb_fa4bit_adder;

  typedef struct packed {
    logic [3:0] s;
    logic       cout;
    logic       v;
    logic       z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t last_exp = '0;

  fa4bit_adder_if bus_if ();

  fa4bit_adder u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: the unsigned sum gives S and Cout, and the signed sum gives overflow.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic cin);
    exp_t e;
    int   u;
    int   sg;
    u      = int'(a) + int'(b) + int'(cin);
    sg     = int'($signed(a)) + int'($signed(b)) + int'(cin);
    e.s    = u[3:0];
    e.cout = u[4];
    e.v    = (sg > 7) || (sg < -8);
    e.z    = (u[3:0] == 4'd0);
    return e;
  endfunction

  task automatic push_exp(input logic [3:0] s, input logic cout, input logic v, input logic z);
    exp_t e;
    e.s = s; e.cout = cout; e.v = v; e.z = z;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, then check the registered outputs just after the edge.
  task automatic step(input string tag, input logic vld, input logic [3:0] a,
                      input logic [3:0] b, input logic cin);
    exp_t e;
    @(negedge clk);
    bus_if.in_valid = vld;
    bus_if.A        = a;
    bus_if.B        = b;
    bus_if.Cin      = cin;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {7'd0, bus_if.out_valid}, {7'd0, vld});
    if (vld) begin
      if (exp_q.size() == 0) begin
        check({tag, ".queue"}, 8'd0, 8'd1);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
      end
    end
    check({tag, ".result"}, {1'b0, bus_if.S, bus_if.Cout, bus_if.V, bus_if.Z},
          {1'b0, last_exp.s, last_exp.cout, last_exp.v, last_exp.z});
  endtask

  initial begin
    // Reset with a live operand. The operand must be dropped.
    bus_if.in_valid = 1'b1;
    bus_if.A        = 4'hF;
    bus_if.B        = 4'hF;
    bus_if.Cin      = 1'b0;
    rst             = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset", {2'b00, bus_if.out_valid, bus_if.S, bus_if.Cout},
            {2'b00, 1'b0, 4'b0000, 1'b0});
      check("reset.flags", {6'd0, bus_if.V, bus_if.Z}, 8'd0);
    end
    @(negedge clk);
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;

    // Directed basic adds.
    push_exp(4'b0000, 1'b0, 1'b0, 1'b1); step("add_0_0",   1'b1, 4'b0000, 4'b0000, 1'b0);
    push_exp(4'b0011, 1'b0, 1'b0, 1'b0); step("add_1_2",   1'b1, 4'b0001, 4'b0010, 1'b0);
    push_exp(4'b1001, 1'b0, 1'b0, 1'b0); step("add_8_1",   1'b1, 4'b1000, 4'b0001, 1'b0);
    push_exp(4'b1101, 1'b0, 1'b1, 1'b0); step("add_7_6",   1'b1, 4'b0111, 4'b0110, 1'b0);
    // Carry-out cases.
    push_exp(4'b0000, 1'b1, 1'b1, 1'b1); step("add_8_8",   1'b1, 4'b1000, 4'b1000, 1'b0);
    push_exp(4'b1110, 1'b1, 1'b0, 1'b0); step("add_f_f",   1'b1, 4'b1111, 4'b1111, 1'b0);
    // Carry-in ripple.
    push_exp(4'b0000, 1'b1, 1'b0, 1'b1); step("add_f_0_c", 1'b1, 4'b1111, 4'b0000, 1'b1);
    push_exp(4'b0001, 1'b0, 1'b0, 1'b0); step("add_0_0_c", 1'b1, 4'b0000, 4'b0000, 1'b1);
    // One valid add followed by three idle cycles. The outputs must hold.
    push_exp(4'b0111, 1'b0, 1'b0, 1'b0); step("add_3_4",   1'b1, 4'b0011, 4'b0100, 1'b0);
    step("idle0", 1'b0, 4'b1111, 4'b1111, 1'b1);
    step("idle1", 1'b0, 4'b1010, 4'b0101, 1'b0);
    step("idle2", 1'b0, 4'b0001, 4'b0001, 1'b1);

    // Exhaustive back-to-back sweep against the reference model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          exp_q.push_back(model(4'(a), 4'(b), 1'(c)));
          step("sweep", 1'b1, 4'(a), 4'(b), 1'(c));
        end
      end
    end
    step("tail_idle", 1'b0, 4'b0000, 4'b0000, 1'b0);
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
